// File: rtl/reg_ctrl_master_if.sv
// Command, reg_ctrl slave and response signals of reg_ctrl_master.
// The master modport is the reg_ctrl_master view; slave is the view of everything around it.
interface reg_ctrl_master_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_wr;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  reg_sel;
   logic                  reg_wr;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [DATA_WIDTH-1:0] reg_wdata;
   logic [DATA_WIDTH-1:0] reg_rdata;
   logic                  reg_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;
   logic                  wr_err;
   logic                  busy;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, reg_rdata, reg_ready, rsp_ready,
      output cmd_ready, reg_sel, reg_wr, reg_addr, reg_wdata,
      output rsp_valid, rsp_data, rsp_err, wr_err, busy
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, reg_rdata, reg_ready, rsp_ready,
      input  cmd_ready, reg_sel, reg_wr, reg_addr, reg_wdata,
      input  rsp_valid, rsp_data, rsp_err, wr_err, busy
   );
endinterface

// File: rtl/reg_ctrl_master.sv
// Generic FIFO, power-of-2 DEPTH; data visible at pop_dat the cycle after push (no bypass).
// push_rdy = !full regardless of a same-cycle pop; pop on empty is ignored.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   output logic             push_rdy,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign push_rdy = (count != (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push_vld & push_rdy;
   assign do_pop   = pop & ~empty;
   assign pop_dat  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end
endmodule

// Sequences buffered commands onto the reg_ctrl sel/wr/ready handshake; read rsp valid 2 edges after pop.
// cmd_ready = command FIFO not full; a stalled rsp_ready holds RSP, so nothing further issues.
module reg_ctrl_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input logic             clk,
   input logic             rst,
   reg_ctrl_master_if.master bus
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RSP} state_t;

   cmd_t   in_cmd;
   cmd_t   head_cmd;
   logic   fifo_empty;
   logic   pop;

   state_t                state_q,     state_nxt;
   logic                  sel_q,       sel_nxt;
   logic                  wr_q,        wr_nxt;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_q,     wdata_nxt;
   logic                  rsp_vld_q,   rsp_vld_nxt;
   logic [DATA_WIDTH-1:0] rsp_dat_q,   rsp_dat_nxt;
   logic                  rsp_err_q,   rsp_err_nxt;
   logic                  wr_err_q,    wr_err_nxt;
   logic [TW-1:0]         tmo_q,       tmo_nxt;

   assign in_cmd = {bus.cmd_wr, bus.cmd_addr, bus.cmd_wdata};

   fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (bus.cmd_valid),
      .push_dat (in_cmd),
      .push_rdy (bus.cmd_ready),
      .pop      (pop),
      .pop_dat  (head_cmd),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_nxt   = state_q;
      sel_nxt     = sel_q;
      wr_nxt      = wr_q;
      addr_nxt    = addr_q;
      wdata_nxt   = wdata_q;
      rsp_vld_nxt = rsp_vld_q;
      rsp_dat_nxt = rsp_dat_q;
      rsp_err_nxt = rsp_err_q;
      wr_err_nxt  = 1'b0;
      tmo_nxt     = tmo_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               sel_nxt   = 1'b1;
               wr_nxt    = head_cmd.wr;
               addr_nxt  = head_cmd.addr;
               wdata_nxt = head_cmd.wdata;
               tmo_nxt   = '0;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.reg_ready) begin
               if (wr_q) begin
                  sel_nxt   = 1'b0;
                  wr_nxt    = 1'b0;
                  state_nxt = IDLE;
               end else begin
                  // slave drops ready next cycle; sel must stay up for it to recover
                  state_nxt = RD_WAIT;
               end
            end else begin
               tmo_nxt = tmo_q + TW'(1);
               if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                  sel_nxt = 1'b0;
                  if (wr_q) begin
                     wr_nxt     = 1'b0;
                     wr_err_nxt = 1'b1;
                     state_nxt  = IDLE;
                  end else begin
                     rsp_vld_nxt = 1'b1;
                     rsp_err_nxt = 1'b1;
                     rsp_dat_nxt = '0;
                     state_nxt   = RSP;
                  end
               end
            end
         end
         RD_WAIT: begin
            rsp_dat_nxt = bus.reg_rdata;
            rsp_err_nxt = 1'b0;
            rsp_vld_nxt = 1'b1;
            sel_nxt     = 1'b0;
            state_nxt   = RSP;
         end
         RSP: begin
            if (bus.rsp_ready) begin
               rsp_vld_nxt = 1'b0;
               rsp_err_nxt = 1'b0;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_vld_q <= 1'b0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
         wr_err_q  <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_nxt;
         sel_q     <= sel_nxt;
         wr_q      <= wr_nxt;
         addr_q    <= addr_nxt;
         wdata_q   <= wdata_nxt;
         rsp_vld_q <= rsp_vld_nxt;
         rsp_dat_q <= rsp_dat_nxt;
         rsp_err_q <= rsp_err_nxt;
         wr_err_q  <= wr_err_nxt;
         tmo_q     <= tmo_nxt;
      end
   end

   assign bus.reg_sel   = sel_q;
   assign bus.reg_wr    = wr_q;
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.rsp_valid = rsp_vld_q;
   assign bus.rsp_data  = rsp_dat_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.wr_err    = wr_err_q;
   assign bus.busy      = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_reg_ctrl_master.sv
// Bench for reg_ctrl_master: reg_ctrl slave model, directed vector table, corner sequences,
// and random traffic scored against an in-order register-array reference.
module tb_reg_ctrl_master;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int DEPTH = 4;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_ctrl_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   reg_ctrl_master #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // reg_ctrl slave: ready drops for one cycle after a read accept and recovers only while sel is held
   logic [DW-1:0] smem [256];
   logic          s_rdy;
   logic [DW-1:0] s_rdata;
   logic          hang;
   logic          stall;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         s_rdy   <= 1'b1;
         s_rdata <= '0;
         for (int i = 0; i < 256; i++) smem[i] <= 16'h1234;
      end else if (bus.reg_sel) begin
         if (bus.reg_ready) begin
            if (bus.reg_wr) smem[bus.reg_addr] <= bus.reg_wdata;
            else begin
               s_rdata <= smem[bus.reg_addr];
               s_rdy   <= 1'b0;
            end
         end else if (!s_rdy) s_rdy <= 1'b1;
      end
   end

   assign bus.reg_ready = s_rdy & ~stall & ~hang;
   assign bus.reg_rdata = s_rdata;

   // reference: register array updated in command order, expected responses in a queue
   typedef struct {
      logic [DW-1:0] data;
      logic          err;
   } rsp_t;

   logic [DW-1:0] mmem [256];
   rsp_t          exp_q [$];

   task automatic model_reset();
      for (int i = 0; i < 256; i++) mmem[i] = 16'h1234;
      exp_q.delete();
   endtask

   // monitor state
   int   cyc = 0;
   int   rdy_mode = 0;
   int   stall_en = 0;
   int   stall_run = 0;
   int   sel_len = 0, last_sel_len = 0, wr_len = 0, last_wr_len = 0;
   int   sel_rise_cyc = 0, rsp_rise_cyc = 0, sel_rises = 0, wr_err_cnt = 0, rsp_cnt = 0;
   logic prev_sel = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0;
   logic [DW-1:0] held_data = '0;
   logic held_err = 1'b0;

   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            bus.rsp_ready = 1'b0;
            stall         = 1'b0;
            prev_sel      = 1'b0;
            prev_vld      = 1'b0;
            prev_rdy      = 1'b0;
            sel_len       = 0;
            wr_len        = 0;
         end else begin
            case (rdy_mode)
               0:       bus.rsp_ready = 1'b1;
               1:       bus.rsp_ready = 1'($urandom_range(0, 1));
               default: bus.rsp_ready = 1'b0;
            endcase
            if (stall_en != 0 && stall_run < 5 && $urandom_range(0, 3) == 0) begin
               stall = 1'b1;
               stall_run++;
            end else begin
               stall     = 1'b0;
               stall_run = 0;
            end

            if (bus.reg_sel) begin
               if (!prev_sel) begin
                  sel_rise_cyc = cyc;
                  sel_rises++;
                  sel_len = 0;
                  wr_len  = 0;
               end
               sel_len++;
               if (bus.reg_wr) wr_len++;
            end else if (prev_sel) begin
               last_sel_len = sel_len;
               last_wr_len  = wr_len;
            end
            prev_sel = bus.reg_sel;

            if (bus.rsp_valid) begin
               if (!prev_vld) rsp_rise_cyc = cyc;
               else if (!prev_rdy) begin
                  chk("rsp_data_stable", 32'(bus.rsp_data), 32'(held_data));
                  chk("rsp_err_stable", 32'(bus.rsp_err), 32'(held_err));
               end
               held_data = bus.rsp_data;
               held_err  = bus.rsp_err;
               if (bus.rsp_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_rsp: got data 0x%0h err %0b, expected no response",
                              bus.rsp_data, bus.rsp_err);
                  end else begin
                     checks--;
                     e = exp_q.pop_front();
                     chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                     chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                  end
                  rsp_cnt++;
               end
            end
            prev_vld = bus.rsp_valid;
            prev_rdy = bus.rsp_ready;
            if (bus.wr_err) wr_err_cnt++;
         end
      end
   end

   // kind: 0 normal, 1 slave will hang (timeout), 2 no response expected by the model
   task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int kind);
      int t = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      while (!bus.cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("push_accept", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (wr) begin
         if (kind == 0) mmem[a] = d;
      end else if (kind == 0) exp_q.push_back('{mmem[a], 1'b0});
      else if (kind == 1) exp_q.push_back('{16'h0000, 1'b1});
   endtask

   task automatic wait_idle(input string name, input int limit);
      int t = 0;
      while ((bus.busy || exp_q.size() != 0) && t < limit) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk({name, "_idle"}, 32'(bus.busy || exp_q.size() != 0), 32'd0);
   endtask

   task automatic check_reset_outputs(input string p);
      chk({p, "_reg_sel"},   32'(bus.reg_sel),   32'd0);
      chk({p, "_reg_wr"},    32'(bus.reg_wr),    32'd0);
      chk({p, "_reg_addr"},  32'(bus.reg_addr),  32'd0);
      chk({p, "_reg_wdata"}, 32'(bus.reg_wdata), 32'd0);
      chk({p, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({p, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
      chk({p, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
      chk({p, "_wr_err"},    32'(bus.wr_err),    32'd0);
      chk({p, "_busy"},      32'(bus.busy),      32'd0);
      chk({p, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_data;
      int            exp_sel;
   } vec_t;

   vec_t vt [10];

   initial begin
      int rises0;
      int cnt0;
      int t;
      logic [DW-1:0] rd;

      vt[0] = '{1'b1, 8'h10, 16'hBEEF, 16'h0000, 1};
      vt[1] = '{1'b0, 8'h10, 16'h0000, 16'hBEEF, 2};
      vt[2] = '{1'b0, 8'h05, 16'h0000, 16'h1234, 2};
      vt[3] = '{1'b1, 8'h05, 16'h00A5, 16'h0000, 1};
      vt[4] = '{1'b0, 8'h05, 16'h0000, 16'h00A5, 2};
      vt[5] = '{1'b1, 8'hFF, 16'hFFFF, 16'h0000, 1};
      vt[6] = '{1'b0, 8'hFF, 16'h0000, 16'hFFFF, 2};
      vt[7] = '{1'b0, 8'h00, 16'h0000, 16'h1234, 2};
      vt[8] = '{1'b1, 8'h10, 16'h0000, 16'h0000, 1};
      vt[9] = '{1'b0, 8'h10, 16'h0000, 16'h0000, 2};

      rst           = 1'b1;
      hang          = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_wr    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;
      @(negedge clk);

      // directed vectors, one command at a time on an always-ready slave
      for (int i = 0; i < 10; i++) begin
         rises0 = sel_rises;
         if (vt[i].wr) push_cmd(1'b1, vt[i].addr, vt[i].wdata, 0);
         else begin
            exp_q.push_back('{vt[i].exp_data, 1'b0});
            push_cmd(1'b0, vt[i].addr, 16'h0000, 2);
         end
         wait_idle($sformatf("vec%0d", i), 50);
         chk($sformatf("vec%0d_issues", i), 32'(sel_rises - rises0), 32'd1);
         chk($sformatf("vec%0d_sel_len", i), 32'(last_sel_len), 32'(vt[i].exp_sel));
         chk($sformatf("vec%0d_wr_len", i), 32'(last_wr_len), vt[i].wr ? 32'd1 : 32'd0);
         if (!vt[i].wr)
            chk($sformatf("vec%0d_rd_latency", i), 32'(rsp_rise_cyc - sel_rise_cyc), 32'd2);
      end

      // response backpressure with two reads queued
      rdy_mode = 2;
      rises0 = sel_rises;
      push_cmd(1'b0, 8'h10, 16'h0000, 0);
      push_cmd(1'b0, 8'h05, 16'h0000, 0);
      repeat (10) @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(bus.rsp_data), 32'(mmem[8'h10]));
      chk("bp_second_held", 32'(sel_rises - rises0), 32'd1);
      chk("bp_reg_sel", 32'(bus.reg_sel), 32'd0);
      rdy_mode = 0;
      wait_idle("bp", 60);
      chk("bp_second_issued", 32'(sel_rises - rises0), 32'd2);

      // fill the FIFO behind a stalled response
      rdy_mode = 2;
      push_cmd(1'b0, 8'h40, 16'h0000, 0);
      t = 0;
      while (!bus.rsp_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("full_first_rsp", 32'(bus.rsp_valid), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         push_cmd(1'b1, AW'(8'h40 + i), DW'($urandom), 0);
         if (i == 3) chk("full_ready_after3", 32'(bus.cmd_ready), 32'd1);
      end
      chk("full_ready_after4", 32'(bus.cmd_ready), 32'd0);
      chk("full_busy", 32'(bus.busy), 32'd1);
      rdy_mode = 0;
      push_cmd(1'b0, 8'h42, 16'h0000, 0);
      push_cmd(1'b0, 8'h44, 16'h0000, 0);
      wait_idle("full", 100);

      // hung slave: read then write time out after TMO cycles in ISSUE
      hang = 1'b1;
      cnt0 = wr_err_cnt;
      push_cmd(1'b0, 8'h33, 16'h0000, 1);
      wait_idle("tmo_rd", 100);
      chk("tmo_rd_sel_len", 32'(last_sel_len), 32'(TMO));
      chk("tmo_rd_latency", 32'(rsp_rise_cyc - sel_rise_cyc), 32'(TMO));
      push_cmd(1'b1, 8'h33, 16'hDEAD, 1);
      wait_idle("tmo_wr", 100);
      chk("tmo_wr_sel_len", 32'(last_sel_len), 32'(TMO));
      chk("tmo_wr_err_pulses", 32'(wr_err_cnt - cnt0), 32'd1);
      hang = 1'b0;
      push_cmd(1'b0, 8'h33, 16'h0000, 0);
      wait_idle("tmo_after", 50);

      // random traffic, random slave stalls and response backpressure
      rdy_mode = 1;
      stall_en = 1;
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         push_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), 0);
      end
      wait_idle("rand", 3000);
      rdy_mode = 0;
      stall_en = 0;
      repeat (2) @(negedge clk);

      // asynchronous reset while a read sits in RD_WAIT, second read still queued
      push_cmd(1'b0, 8'h10, 16'h0000, 2);
      push_cmd(1'b0, 8'h11, 16'h0000, 2);
      t = 0;
      while (!(bus.reg_sel && !bus.reg_ready) && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("rdwait_reached", 32'(bus.reg_sel && !bus.reg_ready), 32'd1);
      #1 rst = 1'b1;
      #1 check_reset_outputs("arst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cnt0 = rsp_cnt;
      repeat (10) @(negedge clk);
      chk("arst_no_rsp", 32'(rsp_cnt - cnt0), 32'd0);
      chk("arst_fifo_empty", 32'(bus.busy), 32'd0);
      rd = mmem[8'h10];
      chk("arst_model_cleared", 32'(rd), 32'h1234);
      push_cmd(1'b0, 8'h10, 16'h0000, 0);
      wait_idle("arst_after", 50);

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end
endmodule
